// File: rtl/cnv_avr_line_scheduler.sv
// Read-side line sequencer between the converter gray-pixel FIFO and the averager:
// waits for a full line, bursts it through a 2-entry skid buffer as framed stream beats.
module cnv_avr_line_scheduler #(
    parameter int IMG_WIDTH  = 416,
    parameter int IMG_HEIGHT = 416,
    parameter int GRAY_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          abort,
    output logic                          fifo_rd_en,
    input  logic [GRAY_WIDTH-1:0]         fifo_rd_data,
    input  logic                          fifo_rd_ack,
    input  logic                          fifo_empty,
    input  logic [$clog2(IMG_WIDTH):0]    fifo_data_count,
    output logic [GRAY_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tuser,
    output logic                          m_tlast,
    output logic                          frame_done,
    output logic                          busy,
    output logic [$clog2(IMG_HEIGHT):0]   line_idx,
    output logic                          rd_err
);
    localparam int CW = $clog2(IMG_WIDTH) + 1;
    localparam int LW = $clog2(IMG_HEIGHT) + 1;
    localparam int EW = GRAY_WIDTH + 2;
    localparam logic [CW-1:0] COL_END   = CW'(IMG_WIDTH);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LINE = 3'd1,
        BURST     = 3'd2,
        DRAIN     = 3'd3,
        FRAME_END = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] rd_col_q, rd_col_d;     // reads issued on this line, minus failed ones
    logic [CW-1:0] ack_col_q, ack_col_d;   // column of the next word to come back
    logic [LW-1:0] line_q, line_d;
    logic          inflight_q, inflight_d;
    logic          rd_err_q, rd_err_d;
    logic          frame_done_q, frame_done_d;

    logic [EW-1:0] skid_q [2];
    logic          skid_rd_ptr_q, skid_rd_ptr_d;
    logic [1:0]    skid_cnt_q, skid_cnt_d;

    logic          ack_ok;
    logic          ack_miss;
    logic          push;
    logic          pop;
    logic          wr_ptr;
    logic [EW-1:0] push_word;
    logic [EW-1:0] head;
    logic [1:0]    slots_used;
    logic          skid_empty_after_pop;
    logic          line_done;

    assign ack_ok   = inflight_q && fifo_rd_ack && !abort;
    assign ack_miss = inflight_q && !fifo_rd_ack && !abort;
    assign push     = ack_ok;
    assign pop      = m_tvalid && m_tready;
    assign wr_ptr   = skid_rd_ptr_q ^ skid_cnt_q[0];

    // Marker bits are attached when the word returns, so they ride with the data.
    assign push_word = {(ack_col_q == '0) && (line_q == '0),
                        (ack_col_q == COL_LAST),
                        fifo_rd_data};

    // A head leaving this cycle frees its slot, which keeps the burst at one pixel per clock.
    assign slots_used = skid_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

    assign fifo_rd_en = (state_q == BURST) && (rd_col_q < COL_END) && !fifo_empty &&
                        (slots_used < 2'd2) && !abort;

    assign skid_empty_after_pop = (skid_cnt_q == 2'd0) || ((skid_cnt_q == 2'd1) && pop);
    assign line_done = (state_q == DRAIN) && (rd_col_q == COL_END) && !inflight_q &&
                       skid_empty_after_pop;

    assign head       = skid_q[skid_rd_ptr_q];
    assign m_tvalid   = (skid_cnt_q != 2'd0);
    assign m_tdata    = head[GRAY_WIDTH-1:0];
    assign m_tlast    = m_tvalid && head[GRAY_WIDTH];
    assign m_tuser    = m_tvalid && head[GRAY_WIDTH+1];
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
    assign line_idx   = line_q;
    assign rd_err     = rd_err_q;

    always_comb begin
        rd_col_d      = rd_col_q + CW'(fifo_rd_en) - CW'(ack_miss);
        ack_col_d     = ack_col_q + CW'(ack_ok);
        inflight_d    = fifo_rd_en;
        rd_err_d      = rd_err_q | ack_miss;
        skid_cnt_d    = skid_cnt_q + {1'b0, push} - {1'b0, pop};
        skid_rd_ptr_d = skid_rd_ptr_q ^ pop;
        if (line_done || abort) begin
            rd_col_d  = '0;
            ack_col_d = '0;
        end
        if (abort) begin
            skid_cnt_d    = 2'd0;
            skid_rd_ptr_d = 1'b0;
            inflight_d    = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_LINE;
            end
            WAIT_LINE: begin
                // Only a frame that has not started yet may be cancelled by dropping enable.
                if (!enable && (line_q == '0))            state_d = IDLE;
                else if (fifo_data_count >= COL_END)      state_d = BURST;
            end
            BURST: begin
                if (rd_col_q == COL_END) state_d = DRAIN;
            end
            DRAIN: begin
                if (rd_col_q != COL_END) begin
                    state_d = BURST;
                end else if (line_done) begin
                    if (line_q == LINE_LAST) begin
                        state_d      = FRAME_END;
                        frame_done_d = 1'b1;
                    end else begin
                        line_d  = line_q + LW'(1);
                        state_d = WAIT_LINE;
                    end
                end
            end
            FRAME_END: begin
                line_d  = '0;
                state_d = enable ? WAIT_LINE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d      = IDLE;
            line_d       = '0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_col_q      <= '0;
            ack_col_q     <= '0;
            line_q        <= '0;
            inflight_q    <= 1'b0;
            rd_err_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            skid_rd_ptr_q <= 1'b0;
            skid_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            rd_col_q      <= rd_col_d;
            ack_col_q     <= ack_col_d;
            line_q        <= line_d;
            inflight_q    <= inflight_d;
            rd_err_q      <= rd_err_d;
            frame_done_q  <= frame_done_d;
            skid_rd_ptr_q <= skid_rd_ptr_d;
            skid_cnt_q    <= skid_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) skid_q[i] <= '0;
        end else if (push) begin
            skid_q[wr_ptr] <= push_word;
        end
    end

endmodule
